// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a single-port registered-read RAM.
// One transaction at a time: IDLE -> ISSUE -> (READ) -> ACK -> IDLE.

module ram_arbiter_port (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cap_i,
  input  logic [15:0] d_i,
  output logic [15:0] q_o
);
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i)      q_o <= '0;
    else if (cap_i) q_o <= d_i;
endmodule

module ram_arbiter #(
  parameter bit RR = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [14:0] addr0,
  input  logic [14:0] addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic [15:0] rdata0,
  output logic [15:0] rdata1,
  output logic        busy,
  output logic        owner,
  output logic        ram_load,
  output logic [14:0] ram_address,
  output logic [15:0] ram_in,
  input  logic [15:0] ram_out
);
  typedef enum logic [1:0] {IDLE, ISSUE, READ, ACK} state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [14:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic        win;
  logic [1:0]  cap;
  logic [1:0][15:0] rdata;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  // Contention goes to the port not served last (RR) or always to port 0.
  always_comb begin
    if (req0 && req1) win = RR ? ~last_q : 1'b0;
    else              win = req1;
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      IDLE: if (req0 || req1) begin
        owner_d = win;
        last_d  = win;
        we_d    = win ? we1    : we0;
        addr_d  = win ? addr1  : addr0;
        wdata_d = win ? wdata1 : wdata0;
        state_d = ISSUE;
      end
      ISSUE:   state_d = we_q ? ACK : READ;
      READ:    state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy        = (state_q != IDLE);
  assign owner       = owner_q;
  assign ram_load    = (state_q == ISSUE) && we_q;
  assign ram_address = addr_q;
  assign ram_in      = wdata_q;
  assign ack0        = (state_q == ACK) && !owner_q;
  assign ack1        = (state_q == ACK) &&  owner_q;

  // RAM read data lands in READ; only the owning port's register loads.
  for (genvar p = 0; p < 2; p++) begin : g_port
    assign cap[p] = (state_q == READ) && (owner_q == p[0]);
    ram_arbiter_port u_port (
      .clk_i (clock),
      .rst_i (reset),
      .cap_i (cap[p]),
      .d_i   (ram_out),
      .q_o   (rdata[p])
    );
  end

  assign rdata0 = rdata[0];
  assign rdata1 = rdata[1];
endmodule
